// File: rtl/double_adder.sv
// double_adder: multi-cycle IEEE-754 binary64 adder, one op in flight.
// Ports: clk, rst (async, active-low), input_valid, input_a, input_b,
//        output_z (sum), done (one-cycle result strobe).
// Macro DOUBLE_ADDER_FAST_ALIGN_EN: single-cycle barrel ALIGN/NORM.
module double_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [63:0] input_a,
  input  logic [63:0] input_b,
  output logic [63:0] output_z,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, ALIGN, ADD,
    NORM, ROUND, PACK, DONE
  } state_t;

  localparam logic signed [12:0] EMIN = -13'sd1022;
  localparam logic signed [12:0] EMAX = 13'sd1023;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  state_t state, w_next;

  logic [63:0]        r_a, r_b, r_z;
  logic               r_sa, r_sb, r_s, r_special;
  logic signed [12:0] r_ea, r_eb, r_e;
  logic [55:0]        r_ma, r_mb;
  logic [56:0]        r_m;

  // Right shift that folds every lost bit into bit 0 (sticky).
  function automatic logic [55:0] f_shr(
    input logic [55:0] m, input logic [5:0] d);
    logic [111:0] x;
    x = {m, 56'b0} >> d;
    return {x[111:57], x[56] | (|x[55:0])};
  endfunction

  function automatic logic signed [12:0] f_exp(
    input logic [10:0] e);
    return (e == 11'd0) ? EMIN
         : $signed({2'b0, e}) - 13'sd1023;
  endfunction

  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic w_a_zero, w_b_zero;
  assign w_a_nan  = (&r_a[62:52]) & (|r_a[51:0]);
  assign w_b_nan  = (&r_b[62:52]) & (|r_b[51:0]);
  assign w_a_inf  = (&r_a[62:52]) & ~(|r_a[51:0]);
  assign w_b_inf  = (&r_b[62:52]) & ~(|r_b[51:0]);
  assign w_a_zero = ~(|r_a[62:0]);
  assign w_b_zero = ~(|r_b[62:0]);

  logic        w_spec;
  logic [63:0] w_spec_z;
  always_comb begin
    w_spec   = 1'b1;
    w_spec_z = '0;
    if (w_a_nan | w_b_nan)
      w_spec_z = QNAN;
    else if (w_a_inf & w_b_inf & (r_a[63] ^ r_b[63]))
      w_spec_z = QNAN;
    else if (w_a_inf)
      w_spec_z = r_a;
    else if (w_b_inf)
      w_spec_z = r_b;
    else if (w_a_zero & w_b_zero)
      w_spec_z = {r_a[63] & r_b[63], 63'b0};
    else if (w_a_zero)
      w_spec_z = r_b;
    else if (w_b_zero)
      w_spec_z = r_a;
    else
      w_spec = 1'b0;
  end

  // Beyond 56 bits every mantissa bit lands in sticky, so one
  // capped shift gives the same result as many single steps.
  logic signed [12:0] w_diff;
  logic [12:0]        w_adiff;
  logic               w_cap;
  logic [5:0]         w_sh;
  assign w_diff  = r_ea - r_eb;
  assign w_adiff = w_diff[12] ? 13'(-w_diff) : 13'(w_diff);
  assign w_cap   = w_adiff >= 13'd56;
`ifdef DOUBLE_ADDER_FAST_ALIGN_EN
  assign w_sh = w_cap ? 6'd56 : w_adiff[5:0];
`else
  assign w_sh = w_cap ? 6'd56 : 6'd1;
`endif

  logic [56:0] w_sum;
  logic        w_sum_s;
  always_comb begin
    w_sum   = '0;
    w_sum_s = r_sa;
    if (r_sa == r_sb)
      w_sum = {1'b0, r_ma} + {1'b0, r_mb};
    else if (r_ma >= r_mb)
      w_sum = {1'b0, r_ma - r_mb};
    else begin
      w_sum   = {1'b0, r_mb - r_ma};
      w_sum_s = r_sb;
    end
  end

`ifdef DOUBLE_ADDER_FAST_ALIGN_EN
  function automatic logic [5:0] f_lzc(input logic [55:0] m);
    logic [5:0] n;
    n = 6'd56;
    for (int i = 0; i < 56; i++)
      if (m[i]) n = 6'(55 - i);
    return n;
  endfunction

  logic [5:0]  w_lz, w_nsh;
  logic [12:0] w_lim;
  assign w_lz  = f_lzc(r_m[55:0]);
  assign w_lim = 13'(r_e - EMIN);
  assign w_nsh = ({7'b0, w_lz} > w_lim) ? w_lim[5:0] : w_lz;
`else
  logic w_norm_busy;
  assign w_norm_busy = r_m[56]
                     | (~r_m[55] & (r_e > EMIN))
                     | (r_e < EMIN);
`endif

  logic [53:0] w_rnd;
  logic        w_up;
  assign w_rnd = {1'b0, r_m[55:3]} + 54'd1;
  assign w_up  = r_m[2] & (r_m[3] | r_m[1] | r_m[0]);

  logic [10:0] w_bexp;
  logic [63:0] w_pack;
  assign w_bexp = r_e[10:0] + 11'd1023;
  always_comb begin
    w_pack = {r_s, w_bexp, r_m[54:3]};
    if (r_e > EMAX)
      w_pack = {r_s, 11'h7FF, 52'b0};
    else if (!r_m[55])
      w_pack = {r_s, 11'b0, r_m[54:3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= w_next;
  end

  // Specials pass through PACK untouched to keep a fixed 4-cycle path.
  always_comb begin
    w_next = state;
    unique case (state)
      IDLE:    if (input_valid) w_next = UNPACK;
      UNPACK:  w_next = SPECIAL;
      SPECIAL: w_next = w_spec ? PACK : ALIGN;
`ifdef DOUBLE_ADDER_FAST_ALIGN_EN
      ALIGN:   w_next = ADD;
      NORM:    w_next = ROUND;
`else
      ALIGN:   if (r_ea == r_eb) w_next = ADD;
      NORM:    if (!w_norm_busy) w_next = ROUND;
`endif
      ADD:     w_next = NORM;
      ROUND:   w_next = PACK;
      PACK:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_z       <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_s       <= 1'b0;
      r_special <= 1'b0;
      r_ea      <= '0;
      r_eb      <= '0;
      r_e       <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_m       <= '0;
      output_z  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (input_valid) begin
          r_a <= input_a;
          r_b <= input_b;
        end
        UNPACK: begin
          r_sa <= r_a[63];
          r_sb <= r_b[63];
          r_ea <= f_exp(r_a[62:52]);
          r_eb <= f_exp(r_b[62:52]);
          r_ma <= {|r_a[62:52], r_a[51:0], 3'b0};
          r_mb <= {|r_b[62:52], r_b[51:0], 3'b0};
        end
        SPECIAL: begin
          r_special <= w_spec;
          r_z       <= w_spec_z;
        end
        ALIGN: begin
          if (r_ea > r_eb) begin
            r_mb <= f_shr(r_mb, w_sh);
            r_eb <= w_cap ? r_ea
                  : r_eb + $signed({7'b0, w_sh});
          end else if (r_eb > r_ea) begin
            r_ma <= f_shr(r_ma, w_sh);
            r_ea <= w_cap ? r_eb
                  : r_ea + $signed({7'b0, w_sh});
          end
        end
        ADD: begin
          r_m <= w_sum;
          r_s <= w_sum_s;
          r_e <= r_ea;
          if (w_sum == '0) begin
            r_s <= 1'b0;
            r_e <= EMIN;
          end
        end
        NORM: begin
          if (r_m[56]) begin
            r_m <= {1'b0, r_m[56:2], r_m[1] | r_m[0]};
            r_e <= r_e + 13'sd1;
`ifdef DOUBLE_ADDER_FAST_ALIGN_EN
          end else begin
            r_m <= r_m << w_nsh;
            r_e <= r_e - $signed({7'b0, w_nsh});
          end
`else
          end else if (!r_m[55] && r_e > EMIN) begin
            r_m <= r_m << 1;
            r_e <= r_e - 13'sd1;
          end else if (r_e < EMIN) begin
            r_m <= {1'b0, r_m[56:2], r_m[1] | r_m[0]};
            r_e <= r_e + 13'sd1;
          end
`endif
        end
        ROUND: if (w_up) begin
          if (w_rnd[53]) begin
            r_m[55:3] <= {1'b1, 52'b0};
            r_e       <= r_e + 13'sd1;
          end else begin
            r_m[55:3] <= w_rnd[52:0];
          end
        end
        PACK: if (!r_special) r_z <= w_pack;
        DONE: begin
          output_z <= r_z;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_double_adder.sv
// tb_double_adder: directed checks of double_adder results,
// latency, done pulse, reset and mid-operation abort.
module tb_double_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        input_valid = 1'b0;
  logic [63:0] input_a = '0;
  logic [63:0] input_b = '0;
  logic [63:0] output_z;
  logic        done;

  int tests = 0;
  int fails = 0;

  double_adder dut (
    .clk         (clk),
    .rst         (rst),
    .input_valid (input_valid),
    .input_a     (input_a),
    .input_b     (input_b),
    .output_z    (output_z),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // lat: expected slow-build latency; norm marks the non-special path
  task automatic op(input string tag,
                    input logic [63:0] a,
                    input logic [63:0] b,
                    input logic [63:0] z,
                    input int lat,
                    input bit norm);
    int n;
    int el;
    bit got;
    el = lat;
`ifdef DOUBLE_ADDER_FAST_ALIGN_EN
    if (norm) el = 8;
`endif
    @(negedge clk);
    input_a = a;
    input_b = b;
    input_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_valid = 1'b0;
    input_a = '1;
    input_b = '1;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      #1 got = done;
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_z"}, output_z, z);
      chk({tag, "_lat"}, 64'(n), 64'(el));
      chk({tag, "_le120"}, 64'(n <= 120), 64'd1);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 64'(done), 64'd0);
      chk({tag, "_hold"}, output_z, z);
    end
  endtask

  initial begin
    bit saw;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_z", output_z, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(dut.state), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    op("p4_p1", 64'h3FD999999999999A, 64'h3FB999999999999A,
       64'h3FE0000000000000, 11, 1'b1);
    op("one_m_one", 64'h3FF0000000000000, 64'hBFF0000000000000,
       64'h0000000000000000, 8, 1'b1);
    op("tie_even", 64'h3FF0000000000000, 64'h3CA0000000000000,
       64'h3FF0000000000000, 61, 1'b1);
    op("above_tie", 64'h3FF0000000000000, 64'h3CA0000000000001,
       64'h3FF0000000000001, 61, 1'b1);
    op("tie_odd", 64'h3FF0000000000001, 64'h3CA0000000000000,
       64'h3FF0000000000002, 61, 1'b1);
    op("cancel52", 64'h3FF0000000000001, 64'hBFF0000000000000,
       64'h3CB0000000000000, 60, 1'b1);
    op("one_m_half_ulp", 64'h3FF0000000000000, 64'hBCA0000000000000,
       64'h3FEFFFFFFFFFFFFF, 62, 1'b1);
    op("two_m_one", 64'h4000000000000000, 64'hBFF0000000000000,
       64'h3FF0000000000000, 10, 1'b1);
    op("m2_p1", 64'hC000000000000000, 64'h3FF0000000000000,
       64'hBFF0000000000000, 10, 1'b1);
    op("one_p_two", 64'h3FF0000000000000, 64'h4000000000000000,
       64'h4008000000000000, 9, 1'b1);
    op("overflow", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF,
       64'h7FF0000000000000, 9, 1'b1);
    op("denorm_min", 64'h0000000000000001, 64'h0000000000000001,
       64'h0000000000000002, 8, 1'b1);
    op("denorm_up", 64'h000FFFFFFFFFFFFF, 64'h0000000000000001,
       64'h0010000000000000, 8, 1'b1);
    op("inf_m_inf", 64'h7FF0000000000000, 64'hFFF0000000000000,
       64'h7FF8000000000000, 4, 1'b0);
    op("nan_a", 64'h7FF0000000000001, 64'h3FF0000000000000,
       64'h7FF8000000000000, 4, 1'b0);
    op("inf_p_one", 64'h3FF0000000000000, 64'hFFF0000000000000,
       64'hFFF0000000000000, 4, 1'b0);
    op("nz_nz", 64'h8000000000000000, 64'h8000000000000000,
       64'h8000000000000000, 4, 1'b0);
    op("pz_nz", 64'h0000000000000000, 64'h8000000000000000,
       64'h0000000000000000, 4, 1'b0);
    op("zero_b", 64'h0000000000000000, 64'hC000000000000000,
       64'hC000000000000000, 4, 1'b0);

    @(negedge clk);
    input_a = 64'h3FD999999999999A;
    input_b = 64'h3FB999999999999A;
    input_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_in_align", 64'(dut.state), 64'd3);
    rst = 1'b0;
    #1;
    chk("abort_state", 64'(dut.state), 64'd0);
    chk("abort_z", output_z, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done) saw = 1'b1;
    end
    chk("abort_no_done", 64'(saw), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    op("after_abort", 64'h3FF0000000000000, 64'h3FF0000000000000,
       64'h4000000000000000, 9, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
